// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler that shares one 16-to-1 datapath mux among 16 requesters,
// with a per-grantee burst limit and a registered, source-tagged copy of the mux output.
module mux16_rr_scheduler #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [15:0]       REQ,
    input  logic [15:0]       REQ_MASK,
    input  logic [DATA_W-1:0] Y,
    output logic [3:0]        SEL,
    output logic [15:0]       GNT,
    output logic              BUSY,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VLD,
    output logic [3:0]        DOUT_SRC
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic [3:0]        dout_src_q, dout_src_d;

    logic [15:0] er;
    logic [15:0] other_req;
    logic [3:0]  search_start;
    logic [3:0]  search_idx;
    logic        search_hit;

    assign er        = REQ & ~REQ_MASK;
    assign other_req = er & ~(16'h0001 << sel_q);

    // Idle arbitration searches from the pointer; any hand-off searches from just past the grantee.
    always_comb begin
        search_start = (state_q == IDLE) ? ptr_q : sel_q + 4'd1;
        search_hit   = 1'b0;
        search_idx   = search_start;
        for (int i = 0; i < 16; i++) begin
            if (!search_hit && er[search_start + 4'(i)]) begin
                search_hit = 1'b1;
                search_idx = search_start + 4'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (er != 16'h0000) begin
                    state_d = GRANT;
                    sel_d   = search_idx;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                if (!er[sel_q]) begin
                    ptr_d = sel_q + 4'd1;
                    cnt_d = 4'd0;
                    if (search_hit) begin
                        sel_d = search_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == BURST_LAST) begin
                    // A lone requester simply restarts its burst rather than bouncing through idle.
                    cnt_d = 4'd0;
                    if (other_req != 16'h0000) begin
                        ptr_d = sel_q + 4'd1;
                        sel_d = search_idx;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        dout_d     = dout_q;
        dout_src_d = dout_src_q;
        dout_vld_d = 1'b0;
        if (state_q == GRANT) begin
            dout_d     = Y;
            dout_src_d = sel_q;
            dout_vld_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            sel_q      <= 4'd0;
            ptr_q      <= 4'd0;
            cnt_q      <= 4'd0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_src_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            dout_src_q <= dout_src_d;
        end
    end

    assign SEL      = sel_q;
    assign BUSY     = (state_q == GRANT);
    assign GNT      = (state_q == GRANT) ? (16'h0001 << sel_q) : 16'h0000;
    assign DOUT     = dout_q;
    assign DOUT_VLD = dout_vld_q;
    assign DOUT_SRC = dout_src_q;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed bench for mux16_rr_scheduler: one instance with a burst limit of 4 and one
// with a burst limit of 1, both driven from the same request/mask/reset stimulus.
module tb_mux16_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] req_mask;
    logic [31:0] y_const;
    logic        use_pat;

    logic [31:0] y0, dout0;
    logic [3:0]  sel0, src0;
    logic [15:0] gnt0;
    logic        busy0, vld0;

    logic [31:0] y1, dout1;
    logic [3:0]  sel1, src1;
    logic [15:0] gnt1;
    logic        busy1, vld1;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] pat(input logic [3:0] s);
        return {s, s, s, s, 16'h1010};
    endfunction

    // The shared mux is modelled as a pure function of the select it is given.
    assign y0 = use_pat ? pat(sel0) : y_const;
    assign y1 = pat(sel1);

    mux16_rr_scheduler #(.DATA_W(32), .MAX_BURST(4)) dut (
        .CLK(clk), .RST(rst_n), .REQ(req), .REQ_MASK(req_mask), .Y(y0),
        .SEL(sel0), .GNT(gnt0), .BUSY(busy0), .DOUT(dout0), .DOUT_VLD(vld0), .DOUT_SRC(src0)
    );

    mux16_rr_scheduler #(.DATA_W(32), .MAX_BURST(1)) dut1 (
        .CLK(clk), .RST(rst_n), .REQ(req), .REQ_MASK(req_mask), .Y(y1),
        .SEL(sel1), .GNT(gnt1), .BUSY(busy1), .DOUT(dout1), .DOUT_VLD(vld1), .DOUT_SRC(src1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Grant invariants on both instances, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("gnt0_onehot0", 32'($onehot0(gnt0)), 32'd1);
            check_output("sel0_matches_gnt", 32'(!busy0 || (gnt0 === (16'h0001 << sel0))), 32'd1);
            check_output("gnt1_onehot0", 32'($onehot0(gnt1)), 32'd1);
            check_output("sel1_matches_gnt", 32'(!busy1 || (gnt1 === (16'h0001 << sel1))), 32'd1);
        end
    end

    logic [15:0] exp_burst [13];
    logic [3:0]  e_sel;
    logic [3:0]  e_prev;

    initial begin
        rst_n    = 1'b0;
        req      = 16'hFFFF;
        req_mask = 16'h0000;
        y_const  = 32'h00012340;
        use_pat  = 1'b0;

        // Reset held with every requester asserting.
        step();
        step();
        check_output("rst_gnt", 32'(gnt0), 32'h0);
        check_output("rst_sel", 32'(sel0), 32'h0);
        check_output("rst_busy", 32'(busy0), 32'h0);
        check_output("rst_vld", 32'(vld0), 32'h0);
        check_output("rst_dout", dout0, 32'h0);
        rst_n = 1'b1;
        step();
        check_output("rst_first_gnt", 32'(gnt0), 32'h0001);
        check_output("rst_first_sel", 32'(sel0), 32'h0);
        check_output("rst_first_busy", 32'(busy0), 32'h1);
        step();
        check_output("rst_dout_val", dout0, 32'h00012340);
        check_output("rst_dout_src", 32'(src0), 32'h0);
        check_output("rst_dout_vld", 32'(vld0), 32'h1);

        // Single requester keeps the grant across burst boundaries.
        do_reset();
        req = 16'h0100;
        for (int i = 0; i < 10; i++) begin
            step();
            check_output("single_gnt", 32'(gnt0), 32'h0100);
            check_output("single_sel", 32'(sel0), 32'd8);
        end
        req = 16'h0000;
        step();
        check_output("drop_gnt", 32'(gnt0), 32'h0);
        check_output("drop_busy", 32'(busy0), 32'h0);
        check_output("drop_sel_hold", 32'(sel0), 32'd8);
        check_output("drop_vld_last", 32'(vld0), 32'h1);
        check_output("drop_src_last", 32'(src0), 32'd8);
        step();
        check_output("drop_vld_clear", 32'(vld0), 32'h0);
        check_output("drop_src_hold", 32'(src0), 32'd8);

        // Full rotation on the burst-of-one instance.
        do_reset();
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            step();
            e_sel = 4'(i);
            check_output("rr_sel", 32'(sel1), 32'(e_sel));
            check_output("rr_gnt", 32'(gnt1), 32'(16'h0001 << e_sel));
            if (i > 0) begin
                e_prev = 4'(i - 1);
                check_output("rr_src", 32'(src1), 32'(e_prev));
                check_output("rr_dout", dout1, pat(e_prev));
                check_output("rr_vld", 32'(vld1), 32'h1);
            end
        end

        // Bursts of four alternating across the 15 -> 0 wrap.
        do_reset();
        req = 16'h8001;
        exp_burst = '{16'h0001, 16'h0001, 16'h0001, 16'h0001,
                      16'h8000, 16'h8000, 16'h8000, 16'h8000,
                      16'h0001, 16'h0001, 16'h0001, 16'h0001,
                      16'h8000};
        for (int i = 0; i < 13; i++) begin
            step();
            check_output("burst_gnt", 32'(gnt0), 32'(exp_burst[i]));
        end

        // Release hands off on the same edge with no idle gap.
        do_reset();
        req = 16'h0028;
        step();
        check_output("handoff_pre_gnt", 32'(gnt0), 32'h0008);
        step();
        check_output("handoff_hold_gnt", 32'(gnt0), 32'h0008);
        req = 16'h0020;
        step();
        check_output("handoff_gnt", 32'(gnt0), 32'h0020);
        check_output("handoff_busy", 32'(busy0), 32'h1);
        check_output("handoff_src", 32'(src0), 32'd3);
        step();
        check_output("handoff_vld", 32'(vld0), 32'h1);
        check_output("handoff_src2", 32'(src0), 32'd5);

        // Masking the grantee behaves like a deassert.
        do_reset();
        req = 16'h0060;
        step();
        check_output("mask_pre_gnt", 32'(gnt0), 32'h0020);
        req_mask = 16'h0020;
        step();
        check_output("mask_move_gnt", 32'(gnt0), 32'h0040);
        req_mask = 16'h0060;
        step();
        check_output("mask_idle_gnt", 32'(gnt0), 32'h0);
        check_output("mask_idle_busy", 32'(busy0), 32'h0);
        req_mask = 16'h0000;

        // Asynchronous reset in the middle of a burst.
        do_reset();
        req     = 16'hFFFF;
        y_const = 32'hDEADBEEF;
        step();
        check_output("midrst_first", 32'(gnt0), 32'h0001);
        step();
        step();
        step();
        step();
        check_output("midrst_second", 32'(gnt0), 32'h0002);
        check_output("midrst_dout_pre", dout0, 32'hDEADBEEF);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("midrst_gnt", 32'(gnt0), 32'h0);
        check_output("midrst_busy", 32'(busy0), 32'h0);
        check_output("midrst_sel", 32'(sel0), 32'h0);
        check_output("midrst_vld", 32'(vld0), 32'h0);
        check_output("midrst_dout", dout0, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        check_output("midrst_ptr_gnt", 32'(gnt0), 32'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
